// File: rtl/vscale_dmem_responder.sv
// vscale_dmem_responder: memory side of the core's dmem address/data-phase
// protocol, backed by an internal flop word array.
// A request is latched in the address phase; the access completes in the last
// data-phase cycle after WAIT_CYCLES wait states.
// Handshake: dmem_en qualifies an address-phase request and is only accepted
// in IDLE or in the final data-phase cycle (dmem_wait = 0). While dmem_wait = 1
// the core holds every input stable and any dmem_en is ignored, not queued.
// Optional feature macro: VSCALE_DMEM_MISALIGN_TRAP_EN. When it is defined,
// misaligned half/word accesses are flagged bad. Otherwise they are silently
// aligned down.
module vscale_dmem_responder #(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dmem_en,
   input  logic        dmem_wen,
   input  logic [2:0]  dmem_size,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata_delayed,
   output logic [31:0] dmem_rdata,
   output logic        dmem_wait,
   output logic        dmem_badmem_e
);

   // Byte-offset width covering the whole array.
   localparam int unsigned AW = $clog2(MEM_WORDS) + 2;

   typedef enum logic {S_IDLE, S_DATA} state_t;

   state_t          state_q, state_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic [AW-1:0]   req_addr_q, req_addr_d;
   logic [2:0]      req_size_q, req_size_d;
   logic            req_wen_q, req_wen_d;
   logic            req_bad_q, req_bad_d;

   logic [31:0]     mem_q [MEM_WORDS];

   logic [31:0]     new_off;
   logic            new_size_ok;
   logic            new_misalign;
   logic            new_bad;

   logic            final_cyc;
   logic [1:0]      lane;
   logic [AW-3:0]   idx;
   logic [31:0]     rd_shifted;
   logic [31:0]     rd_ext;
   logic [3:0]      be;
   logic [31:0]     wdata_sh;
   logic            do_write;

   // Classify the incoming address-phase request (size, range, alignment).
   always_comb begin
      new_off      = dmem_addr - BASE_ADDR;
      new_size_ok  = 1'b0;
      new_misalign = 1'b0;
      case (dmem_size)
         3'd0, 3'd1, 3'd2, 3'd4, 3'd5: new_size_ok = 1'b1;
         default:                      new_size_ok = 1'b0;
      endcase
`ifdef VSCALE_DMEM_MISALIGN_TRAP_EN
      case (dmem_size)
         3'd1, 3'd5: new_misalign = dmem_addr[0];
         3'd2:       new_misalign = |dmem_addr[1:0];
         default:    new_misalign = 1'b0;
      endcase
`endif
      new_bad = !new_size_ok || ((new_off >> AW) != 32'd0) || new_misalign;
   end

   // Next-state logic: latch requests in IDLE or the final cycle, count waits.
   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      req_addr_d = req_addr_q;
      req_size_d = req_size_q;
      req_wen_d  = req_wen_q;
      req_bad_d  = req_bad_q;
      if (state_q == S_DATA && wcnt_q != 4'd0) begin
         wcnt_d = wcnt_q - 4'd1;
      end else if (dmem_en) begin
         state_d    = S_DATA;
         wcnt_d     = 4'(WAIT_CYCLES);
         req_addr_d = dmem_addr[AW-1:0];
         req_size_d = dmem_size;
         req_wen_d  = dmem_wen;
         req_bad_d  = new_bad;
      end else begin
         state_d = S_IDLE;
      end
   end

   // State and request registers; reset drops any pending access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wcnt_q     <= 4'd0;
         req_addr_q <= '0;
         req_size_q <= 3'd0;
         req_wen_q  <= 1'b0;
         req_bad_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         req_addr_q <= req_addr_d;
         req_size_q <= req_size_d;
         req_wen_q  <= req_wen_d;
         req_bad_q  <= req_bad_d;
      end
   end

   // Data-phase datapath: lane select, load extension, store byte enables.
   // With the trap enabled, good half/word accesses are already aligned, so
   // the same lane computation serves both builds.
   always_comb begin
      final_cyc = (state_q == S_DATA) && (wcnt_q == 4'd0);
      idx       = req_addr_q[AW-1:2];
      case (req_size_q[1:0])
         2'd1:    lane = {req_addr_q[1], 1'b0};
         2'd2:    lane = 2'd0;
         default: lane = req_addr_q[1:0];
      endcase
      rd_shifted = mem_q[idx] >> {lane, 3'b000};
      case (req_size_q)
         3'd0:    rd_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
         3'd1:    rd_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
         3'd2:    rd_ext = rd_shifted;
         3'd4:    rd_ext = {24'd0, rd_shifted[7:0]};
         3'd5:    rd_ext = {16'd0, rd_shifted[15:0]};
         default: rd_ext = 32'd0;
      endcase
      case (req_size_q[1:0])
         2'd0:    be = 4'b0001 << lane;
         2'd1:    be = 4'b0011 << lane;
         2'd2:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      wdata_sh      = dmem_wdata_delayed << {lane, 3'b000};
      do_write      = final_cyc && req_wen_q && !req_bad_q;
      dmem_wait     = (state_q == S_DATA) && (wcnt_q != 4'd0);
      dmem_badmem_e = final_cyc && req_bad_q;
      dmem_rdata    = (final_cyc && !req_wen_q && !req_bad_q) ? rd_ext : 32'd0;
   end

   // Word array write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Testbench for vscale_dmem_responder: three instances (0, 3 and 2 wait
// states) share clock and reset. One of them is exercised at a time,
// selected by sel.
module tb_vscale_dmem_responder;

   localparam logic [31:0] BASE = 32'h0000_2000;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_a   [3];
   logic        wen_a  [3];
   logic [2:0]  size_a [3];
   logic [31:0] addr_a [3];
   logic [31:0] wd_a   [3];
   logic [31:0] rd_a   [3];
   logic        wait_a [3];
   logic        bad_a  [3];

   int          waits [3] = '{0, 3, 2};
   int          cyc = 0;
   int          sel = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   logic [31:0] mdl [3][1024];
   // {start[31:0], due[31:0], bad, rdata[31:0]}
   logic [96:0] exp_q[$];

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vscale_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(rst), .dmem_en(en_a[0]), .dmem_wen(wen_a[0]),
      .dmem_size(size_a[0]), .dmem_addr(addr_a[0]), .dmem_wdata_delayed(wd_a[0]),
      .dmem_rdata(rd_a[0]), .dmem_wait(wait_a[0]), .dmem_badmem_e(bad_a[0]));
   vscale_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(rst), .dmem_en(en_a[1]), .dmem_wen(wen_a[1]),
      .dmem_size(size_a[1]), .dmem_addr(addr_a[1]), .dmem_wdata_delayed(wd_a[1]),
      .dmem_rdata(rd_a[1]), .dmem_wait(wait_a[1]), .dmem_badmem_e(bad_a[1]));
   vscale_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .reset(rst), .dmem_en(en_a[2]), .dmem_wen(wen_a[2]),
      .dmem_size(size_a[2]), .dmem_addr(addr_a[2]), .dmem_wdata_delayed(wd_a[2]),
      .dmem_rdata(rd_a[2]), .dmem_wait(wait_a[2]), .dmem_badmem_e(bad_a[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h cyc=%0d inst=%0d", tag, got, exp, cyc, sel);
   endtask

   // reference model helpers
   function automatic logic is_bad(input logic [2:0] size, input logic [31:0] addr);
      logic [31:0] off;
      logic        b;
      off = addr - BASE;
      b = (off >= 32'd4096) || (size == 3'd3) || (size >= 3'd6);
`ifdef VSCALE_DMEM_MISALIGN_TRAP_EN
      if ((size == 3'd1 || size == 3'd5) && addr[0]) b = 1'b1;
      if (size == 3'd2 && addr[1:0] != 2'b00) b = 1'b1;
`endif
      return b;
   endfunction

   function automatic int lane_of(input logic [2:0] size, input logic [31:0] addr);
      if (size[1:0] == 2'd2) return 0;
      if (size[1:0] == 2'd1) return addr[1] ? 2 : 0;
      return int'(addr[1:0]);
   endfunction

   function automatic logic [31:0] ld_exp(input logic [31:0] word, input logic [2:0] size,
                                          input logic [31:0] addr);
      logic [31:0] s;
      s = word >> (8 * lane_of(size, addr));
      case (size)
         3'd0:    return {{24{s[7]}}, s[7:0]};
         3'd1:    return {{16{s[15]}}, s[15:0]};
         3'd2:    return word;
         3'd4:    return {24'd0, s[7:0]};
         3'd5:    return {16'd0, s[15:0]};
         default: return 32'd0;
      endcase
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata);
      logic        b;
      logic [31:0] rd;
      logic [31:0] w;
      int          idx;
      int          l;
      en_a[sel] = 1'b1; wen_a[sel] = wen; size_a[sel] = size; addr_a[sel] = addr;
      b  = is_bad(size, addr);
      rd = 32'd0;
      if (!b) begin
         idx = int'((addr - BASE) >> 2);
         l   = lane_of(size, addr);
         if (!wen) rd = ld_exp(mdl[sel][idx], size, addr);
         else begin
            w = mdl[sel][idx];
            case (size[1:0])
               2'd0:    w[8*l +: 8]  = wdata[7:0];
               2'd1:    w[8*l +: 16] = wdata[15:0];
               default: w = wdata;
            endcase
            mdl[sel][idx] = w;
         end
      end
      exp_q.push_back({32'(cyc + 1), 32'(cyc + 1 + waits[sel]), b, rd});
      tick();
      en_a[sel] = 1'b0;
      wd_a[sel] = wdata;
   endtask

   // Present a request without expecting it to be taken yet.
   task automatic hold(input logic wen, input logic [2:0] size, input logic [31:0] addr);
      en_a[sel] = 1'b1; wen_a[sel] = wen; size_a[sel] = size; addr_a[sel] = addr;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() > 0 && k < 64) begin
         tick();
         k++;
      end
      check("drain_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      logic        exp_wait;
      logic [96:0] f;
      if (!rst) begin
         exp_wait = 1'b0;
         f = '0;
         if (exp_q.size() > 0) begin
            f = exp_q[0];
            exp_wait = (f[96:65] <= 32'(cyc)) && (32'(cyc) < f[64:33]);
         end
         check("dmem_wait", wait_a[sel], exp_wait);
         if (exp_q.size() > 0 && f[64:33] == 32'(cyc)) begin
            check("rdata", rd_a[sel], f[31:0]);
            check("badmem", bad_a[sel], f[32]);
            void'(exp_q.pop_front());
         end else begin
            check("rdata_idle", rd_a[sel], 32'd0);
            check("badmem_idle", bad_a[sel], 32'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  sz;
      logic [31:0] ad;
      logic [31:0] old;
      for (int k = 0; k < 3; k++) begin
         en_a[k] = 1'b0; wen_a[k] = 1'b0; size_a[k] = 3'd0; addr_a[k] = 32'd0; wd_a[k] = 32'd0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_wait", wait_a[k], 32'd0);
         check("rst_bad", bad_a[k], 32'd0);
         check("rst_rdata", rd_a[k], 32'd0);
      end
      rst = 1'b0;
      tick();

      // zero wait states: preload words 0..15, then directed tests
      sel = 0;
      for (int i = 0; i < 16; i++) req(1'b1, 3'd2, BASE + 32'(4 * i), $urandom);
      req(1'b1, 3'd2, 32'h2010, 32'hDEAD_BEEF);
      req(1'b0, 3'd2, 32'h2010, 32'd0);
      req(1'b1, 3'd0, 32'h2013, 32'h0000_0080);
      req(1'b0, 3'd2, 32'h2010, 32'd0);
      req(1'b0, 3'd0, 32'h2013, 32'd0);
      req(1'b0, 3'd4, 32'h2013, 32'd0);
      req(1'b1, 3'd1, 32'h2016, 32'h0000_8001);
      req(1'b0, 3'd1, 32'h2016, 32'd0);
      req(1'b0, 3'd5, 32'h2016, 32'd0);
      req(1'b1, 3'd2, 32'h2000, 32'h1122_3344);
      req(1'b1, 3'd2, 32'h3000, 32'hFFFF_FFFF);
      req(1'b1, 3'd2, 32'h1FFC, 32'hFFFF_FFFF);
      req(1'b0, 3'd2, 32'h2000, 32'd0);
      req(1'b0, 3'd3, 32'h2004, 32'd0);
      req(1'b0, 3'd2, 32'h2012, 32'd0);
      req(1'b1, 3'd1, 32'h2015, 32'h0000_ABCD);
      req(1'b0, 3'd2, 32'h2014, 32'd0);
      idle(2);
      drain();

      // random mix inside and just outside the window, including illegal sizes
      for (int i = 0; i < 40; i++) begin
         sz = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) ad = 32'h3000 + 32'($urandom_range(0, 15));
         else ad = BASE + 32'($urandom_range(0, 63));
         req(1'($urandom_range(0, 1)), sz, ad, $urandom);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(1);
      drain();

      // three wait states: ignored request during waits, accepted in final cycle
      sel = 1;
      req(1'b1, 3'd2, 32'h2020, 32'hA5A5_5A5A);
      idle(3);
      req(1'b0, 3'd2, 32'h2020, 32'd0);
      hold(1'b0, 3'd4, 32'h2023);
      idle(3);
      req(1'b0, 3'd4, 32'h2023, 32'd0);
      idle(4);
      drain();

      // two wait states: reset during the second wait cycle of a store
      sel = 2;
      req(1'b1, 3'd2, 32'h2030, 32'hCAFE_F00D);
      idle(2);
      drain();
      old = mdl[2][12];
      req(1'b1, 3'd2, 32'h2030, 32'h0BAD_F00D);
      tick();
      #1;
      rst = 1'b1;
      #1;
      check("midrst_wait", wait_a[2], 32'd0);
      check("midrst_bad", bad_a[2], 32'd0);
      check("midrst_rdata", rd_a[2], 32'd0);
      exp_q.delete();
      mdl[2][12] = old;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      req(1'b0, 3'd2, 32'h2030, 32'd0);
      idle(2);
      req(1'b0, 3'd1, 32'h2032, 32'd0);
      idle(3);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
